// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the unified memory port arbiter:
//   - FSM state encodings (legacy localparam constants plus a typed enum)
//   - port select encodings SEL_IF / SEL_MEM
//   - cnt_width(): width of the WAIT down-counter for a given read latency
// No ports (package).
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        DONE  = ST_DONE
    } arb_state_e;

    localparam logic SEL_IF  = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    // The counter holds LAT-1 at most; keep at least one bit so LAT = 1
    // still elaborates a legal (if unused) register.
    function automatic int cnt_width(input int lat);
        if (lat <= 2) begin
            return 1;
        end
        return $clog2(lat);
    endfunction

endpackage : mem_arb_pkg

// File: rtl/mux_2x1.sv
// ---------------------------------------------------------------------------
// mux_2x1
// Generic two-input multiplexer.
// Ports:
//   i_sel  select, 0 = i_a, 1 = i_b
//   i_a    input 0
//   i_b    input 1
//   o_y    selected output
// ---------------------------------------------------------------------------
module mux_2x1 #(
    parameter int N = 32
) (
    input  logic         i_sel,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule : mux_2x1

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported instruction/data memory between the fetch (IF)
// and memory (MEM) pipeline stages. One access at a time runs through a
// fixed-latency transaction IDLE -> ISSUE -> [WAIT] -> DONE; the granted
// stage gets a one-cycle done pulse with read data passed straight through
// from the memory in DONE.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   : tie goes to the stage not served last
//                                   (MEM wins the first tie after reset)
//                       undefined : fixed priority, MEM beats IF on a tie
//
// Parameters: N (data width), ADDR_W (address width), LAT (read latency 1..15)
// Ports:
//   i_clk, i_rst_n                   clock, async active-low reset
//   i_if_req, i_if_addr              fetch request / address
//   o_if_done, o_if_rdata            fetch done pulse / instruction word
//   i_mem_req, i_mem_we, i_mem_addr,
//   i_mem_wdata                      data request / store flag / addr / data
//   o_mem_done, o_mem_rdata          data done pulse / load data
//   o_port_sel                       memory mux select, 0 = IF, 1 = MEM
//   o_ram_en, o_ram_we, o_ram_addr,
//   o_ram_wdata, i_ram_rdata         memory port
//   o_stall_if, o_stall_mem          pending-request stalls for hazard logic
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int N      = 32,
    parameter int ADDR_W = 32,
    parameter int LAT    = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_done,
    output logic [N-1:0]      o_if_rdata,
    input  logic              i_mem_req,
    input  logic              i_mem_we,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [N-1:0]      i_mem_wdata,
    output logic              o_mem_done,
    output logic [N-1:0]      o_mem_rdata,
    output logic              o_port_sel,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [N-1:0]      o_ram_wdata,
    input  logic [N-1:0]      i_ram_rdata,
    output logic              o_stall_if,
    output logic              o_stall_mem
);

    import mem_arb_pkg::*;

    // state | meaning
    // IDLE  | no access in flight; sample requests, latch winner into port_sel
    // ISSUE | ram_en strobe for one cycle, load latency counter
    // WAIT  | count down remaining latency (skipped when LAT = 1)
    // DONE  | pulse granted done, pass ram_rdata through, return to IDLE

    localparam int              CNT_W    = cnt_width(LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic             r_port_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_if_rdata;
    logic [N-1:0]     r_mem_rdata;

    logic             w_any_req;
    logic             w_tie_sel;
    logic             w_win_sel;
    logic             w_in_done;
    logic             w_if_done;
    logic             w_mem_done;

`ifdef ARB_ROUND_ROBIN_EN
    // Last-served stage; resets to IF so MEM takes the first tie.
    logic r_last_sel;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_sel <= SEL_IF;
        end else if (r_state == DONE) begin
            r_last_sel <= r_port_sel;
        end
    end

    assign w_tie_sel = ~r_last_sel;
`else
    assign w_tie_sel = SEL_MEM;
`endif

    assign w_any_req = i_if_req | i_mem_req;

    always_comb begin
        w_win_sel = SEL_IF;
        if (i_if_req && i_mem_req) begin
            w_win_sel = w_tie_sel;
        end else if (i_mem_req) begin
            w_win_sel = SEL_MEM;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = (LAT > 1) ? WAIT : DONE;
            end
            WAIT: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_port_sel <= SEL_IF;
            r_cnt      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_any_req) begin
                r_port_sel <= w_win_sel;
            end
            if (r_state == ISSUE) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

    // Hold the last delivered word per stage so the non-granted output is
    // stable rather than following unrelated memory traffic.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            if (w_if_done) begin
                r_if_rdata <= i_ram_rdata;
            end
            if (w_mem_done) begin
                r_mem_rdata <= i_ram_rdata;
            end
        end
    end

    assign w_in_done  = (r_state == DONE);
    assign w_if_done  = w_in_done & (r_port_sel == SEL_IF);
    assign w_mem_done = w_in_done & (r_port_sel == SEL_MEM);

    assign o_if_done   = w_if_done;
    assign o_mem_done  = w_mem_done;
    assign o_if_rdata  = w_if_done  ? i_ram_rdata : r_if_rdata;
    assign o_mem_rdata = w_mem_done ? i_ram_rdata : r_mem_rdata;

    // Decoded from the state register so an async reset drops the strobe
    // without waiting for a clock edge.
    assign o_port_sel  = r_port_sel;
    assign o_ram_en    = (r_state == ISSUE);
    assign o_ram_we    = (r_state == ISSUE) & r_port_sel & i_mem_we;
    assign o_ram_wdata = i_mem_wdata;

    mux_2x1 #(
        .N (ADDR_W)
    ) u_addr_mux (
        .i_sel (r_port_sel),
        .i_a   (i_if_addr),
        .i_b   (i_mem_addr),
        .o_y   (o_ram_addr)
    );

    assign o_stall_if  = i_if_req  & ~w_if_done;
    assign o_stall_mem = i_mem_req & ~w_mem_done;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;

    // LAT = 2 instance
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata, ram_rdata;
    logic        if_done, mem_done, port_sel, ram_en, ram_we, stall_if, stall_mem;
    logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;

    // LAT = 1 instance
    logic        l1_if_req, l1_mem_req, l1_mem_we;
    logic [31:0] l1_if_addr, l1_mem_addr, l1_mem_wdata, l1_ram_rdata;
    logic        l1_if_done, l1_mem_done, l1_port_sel, l1_ram_en, l1_ram_we;
    logic        l1_stall_if, l1_stall_mem;
    logic [31:0] l1_if_rdata, l1_mem_rdata, l1_ram_addr, l1_ram_wdata;

    int n_total = 0;
    int n_bad   = 0;

    mem_port_arbiter #(.N(32), .ADDR_W(32), .LAT(2)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_done(if_done), .o_if_rdata(if_rdata),
        .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr),
        .i_mem_wdata(mem_wdata),
        .o_mem_done(mem_done), .o_mem_rdata(mem_rdata),
        .o_port_sel(port_sel), .o_ram_en(ram_en), .o_ram_we(ram_we),
        .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
        .o_stall_if(stall_if), .o_stall_mem(stall_mem)
    );

    mem_port_arbiter #(.N(32), .ADDR_W(32), .LAT(1)) u_dut_l1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(l1_if_req), .i_if_addr(l1_if_addr),
        .o_if_done(l1_if_done), .o_if_rdata(l1_if_rdata),
        .i_mem_req(l1_mem_req), .i_mem_we(l1_mem_we), .i_mem_addr(l1_mem_addr),
        .i_mem_wdata(l1_mem_wdata),
        .o_mem_done(l1_mem_done), .o_mem_rdata(l1_mem_rdata),
        .o_port_sel(l1_port_sel), .o_ram_en(l1_ram_en), .o_ram_we(l1_ram_we),
        .o_ram_addr(l1_ram_addr), .o_ram_wdata(l1_ram_wdata), .i_ram_rdata(l1_ram_rdata),
        .o_stall_if(l1_stall_if), .o_stall_mem(l1_stall_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_sel;

        rst_n = 1'b0;
        if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
        if_addr = 32'h40; mem_addr = 32'h80; mem_wdata = 32'h0; ram_rdata = 32'h0;
        l1_if_req = 1'b0; l1_mem_req = 1'b0; l1_mem_we = 1'b0;
        l1_if_addr = 32'h0; l1_mem_addr = 32'h0; l1_mem_wdata = 32'h0; l1_ram_rdata = 32'h0;

        // Reset with both requests high
        repeat (3) step();
        chk_val("rst_ram_en",   32'(ram_en),   32'd0);
        chk_val("rst_port_sel", 32'(port_sel), 32'd0);
        chk_val("rst_if_done",  32'(if_done),  32'd0);
        chk_val("rst_mem_done", 32'(mem_done), 32'd0);
        chk_val("rst_ram_addr", ram_addr,      32'h40);
        chk_val("rst_stall_if", 32'(stall_if), 32'd1);

        // Release: sustained contention, 4 accesses, 4 cycles each
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_sel = (RR && (i % 2 == 1)) ? 1'b0 : 1'b1;
            step(); // ISSUE
            chk_val($sformatf("cont%0d_sel", i),    32'(port_sel), 32'(exp_sel));
            chk_val($sformatf("cont%0d_ram_en", i), 32'(ram_en),   32'd1);
            chk_val($sformatf("cont%0d_addr", i),   ram_addr, exp_sel ? 32'h80 : 32'h40);
            ram_rdata = 32'hC0DE_0000 + i;
            step(); // WAIT
            chk_val($sformatf("cont%0d_wait_en", i), 32'(ram_en), 32'd0);
            step(); // DONE
            chk_val($sformatf("cont%0d_if_done", i),  32'(if_done),  32'(!exp_sel));
            chk_val($sformatf("cont%0d_mem_done", i), 32'(mem_done), 32'(exp_sel));
            chk_val($sformatf("cont%0d_stall_if", i), 32'(stall_if), 32'(exp_sel));
            chk_val($sformatf("cont%0d_rdata", i), exp_sel ? mem_rdata : if_rdata,
                    32'hC0DE_0000 + i);
            if (i == 3) begin
                if_req = 1'b0;
                mem_req = 1'b0;
            end
            step(); // IDLE
        end
        chk_val("idle_ram_en", 32'(ram_en), 32'd0);

        // Single fetch, LAT = 2
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        chk_val("f_stall_if_c0", 32'(stall_if), 32'd1);
        step(); // cycle 1
        chk_val("f_ram_en_c1", 32'(ram_en),   32'd1);
        chk_val("f_addr_c1",   ram_addr,      32'h100);
        chk_val("f_sel_c1",    32'(port_sel), 32'd0);
        chk_val("f_we_c1",     32'(ram_we),   32'd0);
        step(); // cycle 2
        chk_val("f_done_c2",   32'(if_done),  32'd0);
        ram_rdata = 32'h0050_0093;
        step(); // cycle 3
        chk_val("f_done_c3",   32'(if_done),  32'd1);
        chk_val("f_rdata_c3",  if_rdata,      32'h0050_0093);
        chk_val("f_mdone_c3",  32'(mem_done), 32'd0);
        if_req = 1'b0;
        step(); // cycle 4
        chk_val("f_stall_c4",  32'(stall_if), 32'd0);
        chk_val("f_done_c4",   32'(if_done),  32'd0);
        ram_rdata = 32'h1111_1111;
        #1;
        chk_val("f_rdata_hold", if_rdata, 32'h0050_0093);

        // Store, LAT = 2
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2000; mem_wdata = 32'hDEAD_BEEF;
        #1;
        chk_val("st_stall_mem", 32'(stall_mem), 32'd1);
        step(); // ISSUE
        chk_val("st_ram_en",  32'(ram_en),   32'd1);
        chk_val("st_ram_we",  32'(ram_we),   32'd1);
        chk_val("st_sel",     32'(port_sel), 32'd1);
        chk_val("st_addr",    ram_addr,      32'h2000);
        chk_val("st_wdata",   ram_wdata,     32'hDEAD_BEEF);
        step(); // WAIT
        chk_val("st_wait_en", 32'(ram_en),   32'd0);
        chk_val("st_wait_we", 32'(ram_we),   32'd0);
        chk_val("st_wait_dn", 32'(mem_done), 32'd0);
        step(); // DONE
        chk_val("st_done",    32'(mem_done), 32'd1);
        chk_val("st_if_done", 32'(if_done),  32'd0);
        chk_val("st_stall",   32'(stall_mem), 32'd0);
        mem_req = 1'b0; mem_we = 1'b0;
        step(); // IDLE
        chk_val("st_done_off", 32'(mem_done), 32'd0);

        // Load, LAT = 2
        mem_req = 1'b1; mem_addr = 32'h3000;
        step(); // ISSUE
        chk_val("ld_we",    32'(ram_we), 32'd0);
        chk_val("ld_addr",  ram_addr,    32'h3000);
        ram_rdata = 32'h1234_5678;
        step(); step(); // DONE
        chk_val("ld_done",  32'(mem_done), 32'd1);
        chk_val("ld_rdata", mem_rdata,     32'h1234_5678);
        mem_req = 1'b0;
        step();

        // Abort during WAIT of an IF access
        if_req = 1'b1; if_addr = 32'h400;
        step(); // ISSUE
        step(); // WAIT
        rst_n = 1'b0;
        #1;
        chk_val("ab_ram_en", 32'(ram_en),  32'd0);
        chk_val("ab_done",   32'(if_done), 32'd0);
        step();
        chk_val("ab_done2",  32'(if_done), 32'd0);
        chk_val("ab_en2",    32'(ram_en),  32'd0);
        rst_n = 1'b1;
        #1; // IDLE
        step(); // ISSUE
        chk_val("ab_re_en",   32'(ram_en),   32'd1);
        chk_val("ab_re_addr", ram_addr,      32'h400);
        chk_val("ab_re_sel",  32'(port_sel), 32'd0);
        ram_rdata = 32'hABCD_0400;
        step(); // WAIT
        chk_val("ab_re_wait", 32'(if_done),  32'd0);
        step(); // DONE
        chk_val("ab_re_done",  32'(if_done), 32'd1);
        chk_val("ab_re_rdata", if_rdata,     32'hABCD_0400);
        if_req = 1'b0;
        step();

        // Abort during ISSUE: strobe must drop without a clock edge
        mem_req = 1'b1; mem_addr = 32'h500;
        step(); // ISSUE
        chk_val("ai_en_pre", 32'(ram_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_val("ai_en_async", 32'(ram_en), 32'd0);
        chk_val("ai_sel",      32'(port_sel), 32'd0);
        mem_req = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // LAT = 1: back-to-back fetches, 3 cycles each
        l1_if_req = 1'b1; l1_if_addr = 32'h10;
        step(); // ISSUE
        chk_val("l1a_en",   32'(l1_ram_en), 32'd1);
        chk_val("l1a_addr", l1_ram_addr,    32'h10);
        l1_ram_rdata = 32'h0000_00A1;
        step(); // DONE
        chk_val("l1a_done",  32'(l1_if_done), 32'd1);
        chk_val("l1a_rdata", l1_if_rdata,     32'h0000_00A1);
        chk_val("l1a_en_off", 32'(l1_ram_en), 32'd0);
        l1_if_addr = 32'h14;
        step(); // IDLE
        chk_val("l1_idle_done", 32'(l1_if_done), 32'd0);
        chk_val("l1_idle_en",   32'(l1_ram_en),  32'd0);
        chk_val("l1_idle_hold", l1_if_rdata,     32'h0000_00A1);
        step(); // ISSUE
        chk_val("l1b_en",   32'(l1_ram_en), 32'd1);
        chk_val("l1b_addr", l1_ram_addr,    32'h14);
        l1_ram_rdata = 32'h0000_00B2;
        step(); // DONE
        chk_val("l1b_done",  32'(l1_if_done), 32'd1);
        chk_val("l1b_rdata", l1_if_rdata,     32'h0000_00B2);
        chk_val("l1b_mdone", 32'(l1_mem_done), 32'd0);
        l1_if_req = 1'b0;
        step();
        chk_val("l1_end_done",  32'(l1_if_done),  32'd0);
        chk_val("l1_end_stall", 32'(l1_stall_if), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_mem_port_arbiter
